// File: rtl/fcvt_int_to_half_pkg.sv
// Shared types and constants for the integer-to-half converter.
package fcvt_int_to_half_pkg;

  typedef enum logic [1:0] {
    FUNCT_H_W  = 2'd0,
    FUNCT_H_WU = 2'd1,
    FUNCT_W_H  = 2'd2,
    FUNCT_WU_H = 2'd3
  } fpu_cvt_type_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fpu_rm_t;

  typedef logic [2:0] fcvt_state_t;
  localparam fcvt_state_t IDLE  = 3'd0;
  localparam fcvt_state_t ABS   = 3'd1;
  localparam fcvt_state_t NORM  = 3'd2;
  localparam fcvt_state_t ROUND = 3'd3;
  localparam fcvt_state_t DONE  = 3'd4;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_flags_t;

  localparam int unsigned HALF_BIAS       = 15;
  localparam logic [15:0] HALF_MAX_FINITE = 16'h7BFF;
  localparam logic [15:0] HALF_CANON_NAN  = 16'h7E00;

endpackage

// File: rtl/fcvt_int_to_half_round.sv
// Combinational rounding of a normalized magnitude to half precision.
// FCVT_ROUND_MODES_EN enables all RISC-V rounding modes; otherwise RNE only.
module fcvt_half_round
  import fcvt_int_to_half_pkg::*;
(
  input  logic        sign,
  input  logic [4:0]  e,
  input  logic [30:0] mag,
  input  fpu_rm_t     rm,
  output logic [15:0] half,
  output fpu_flags_t  flags
);

  logic [9:0]  frac;
  logic        g, s, nx, inc, to_inf, bad_rm;
  logic [10:0] sum;
  logic [5:0]  e_r;

`ifndef FCVT_ROUND_MODES_EN
  logic unused_rm;
  assign unused_rm = ^rm;
`endif

  always_comb begin
    frac   = mag[30:21];
    g      = mag[20];
    s      = |mag[19:0];
    nx     = g | s;
    inc    = 1'b0;
    to_inf = 1'b1;
    bad_rm = 1'b0;
`ifdef FCVT_ROUND_MODES_EN
    case (rm)
      RM_RNE: inc = g & (s | frac[0]);
      RM_RTZ: to_inf = 1'b0;
      RM_RDN: begin inc = sign & nx;  to_inf = sign;  end
      RM_RUP: begin inc = ~sign & nx; to_inf = ~sign; end
      RM_RMM: inc = g;
      default: bad_rm = 1'b1;
    endcase
`else
    inc = g & (s | frac[0]);
`endif
    // Carry out of the fraction bumps the exponent and leaves a zero fraction.
    sum      = {1'b0, frac} + {10'd0, inc};
    e_r      = {1'b0, e} + {5'd0, sum[10]};
    flags    = '0;
    flags.nx = nx;
    if (bad_rm) begin
      half     = HALF_CANON_NAN;
      flags    = '0;
      flags.nv = 1'b1;
    end else if (e_r > 6'd15) begin
      half     = to_inf ? {sign, 5'h1F, 10'h000} : {sign, HALF_MAX_FINITE[14:0]};
      flags.of = 1'b1;
      flags.nx = 1'b1;
    end else begin
      half = {sign, e_r[4:0] + 5'(HALF_BIAS), sum[9:0]};
    end
  end

endmodule

// File: rtl/fcvt_int_to_half.sv
// Iterative int32/uint32 to half-float converter with valid/ready handshakes.
// Optional FCVT_ROUND_MODES_EN honours in_frm; otherwise RNE is always used.
module fcvt_int_to_half
  import fcvt_int_to_half_pkg::*;
#(
  parameter int unsigned SHIFT_PER_CYCLE = 4,
  parameter bit          BOX_UPPER       = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  fpu_cvt_type_t in_cvt,
  input  logic [2:0]    in_frm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [4:0]    out_flags
);

  fcvt_state_t   state_q, state_d;
  logic [31:0]   mag_q, mag_d, abs_mag, norm_mag;
  logic [4:0]    sh_q, sh_d, norm_sh;
  logic          sign_q, sign_d;
  fpu_cvt_type_t cvt_q, cvt_d;
  logic [2:0]    frm_q, frm_d;
  logic [15:0]   result_q, result_d, rnd_half;
  fpu_flags_t    flags_q, flags_d, rnd_flags;

  fcvt_half_round u_round (
    .sign  (sign_q),
    .e     (5'd31 - sh_q),
    .mag   (mag_q[30:0]),
    .rm    (fpu_rm_t'(frm_q)),
    .half  (rnd_half),
    .flags (rnd_flags)
  );

  always_comb begin
    abs_mag  = sign_q ? (~mag_q + 32'd1) : mag_q;
    norm_mag = mag_q;
    norm_sh  = sh_q;
    // Single-bit steps stop at the leading one, so the shift never overshoots.
    for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (!norm_mag[31]) begin
        norm_mag = norm_mag << 1;
        norm_sh  = norm_sh + 5'd1;
      end
    end

    state_d  = state_q;
    mag_d    = mag_q;
    sh_d     = sh_q;
    sign_d   = sign_q;
    cvt_d    = cvt_q;
    frm_d    = frm_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ABS;
          mag_d   = in_data;
          sh_d    = 5'd0;
          sign_d  = (in_cvt == FUNCT_H_W) && in_data[31];
          cvt_d   = in_cvt;
          frm_d   = in_frm;
        end
      end
      ABS: begin
        mag_d = abs_mag;
        if (cvt_q == FUNCT_W_H || cvt_q == FUNCT_WU_H) begin
          result_d   = HALF_CANON_NAN;
          flags_d    = '0;
          flags_d.nv = 1'b1;
          state_d    = DONE;
        end else if (mag_q == 32'd0) begin
          result_d = 16'h0000;
          flags_d  = '0;
          state_d  = DONE;
        end else begin
          state_d = abs_mag[31] ? ROUND : NORM;
        end
      end
      NORM: begin
        mag_d = norm_mag;
        sh_d  = norm_sh;
        if (norm_mag[31]) state_d = ROUND;
      end
      ROUND: begin
        result_d = rnd_half;
        flags_d  = rnd_flags;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      sh_q     <= '0;
      sign_q   <= 1'b0;
      cvt_q    <= FUNCT_H_W;
      frm_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      sh_q     <= sh_d;
      sign_q   <= sign_d;
      cvt_q    <= cvt_d;
      frm_q    <= frm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? {(BOX_UPPER ? 16'hFFFF : 16'h0000), result_q} : 32'd0;
  assign out_flags = out_valid ? flags_q : 5'd0;

endmodule

// File: tb/tb_fcvt_int_to_half.sv
// Directed self-checking bench for fcvt_int_to_half (default build, RNE).
module tb_fcvt_int_to_half;
  import fcvt_int_to_half_pkg::*;

  logic          CLK = 1'b0;
  logic          RST, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_data, out_data;
  fpu_cvt_type_t in_cvt;
  logic [2:0]    in_frm;
  logic [4:0]    out_flags;
  int            n_checks = 0;
  int            n_fail   = 0;

  fcvt_int_to_half #(
    .SHIFT_PER_CYCLE (4),
    .BOX_UPPER       (1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cvt    (in_cvt),
    .in_frm    (in_frm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operand, wait for the result and complete the handshake.
  task automatic convert(input string tag, input fpu_cvt_type_t cvt, input logic [31:0] data,
                         input logic [31:0] exp_data, input logic [4:0] exp_flags,
                         input int exp_lat);
    int lat;
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_cvt   = cvt;
    in_data  = data;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " data"}, out_data, exp_data);
    check_eq({tag, " flags"}, 32'(out_flags), 32'(exp_flags));
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check_eq({tag, " released"}, 32'(out_valid), 32'd0);
  endtask

  // Start a conversion of 1 and abort it while it is normalizing.
  task automatic abort_in_norm(input string tag, input bit use_rst);
    in_valid = 1'b1;
    in_cvt   = FUNCT_H_W;
    in_data  = 32'd1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    if (use_rst) RST = 1'b1;
    else flush = 1'b1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    flush = 1'b0;
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " out_data"}, out_data, 32'd0);
    convert({tag, " then 3"}, FUNCT_H_W, 32'd3, 32'hFFFF4200, 5'b00000, 11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cvt    = FUNCT_H_W;
    in_frm    = 3'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_eq("reset in_ready", 32'(in_ready), 32'd1);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset out_data", out_data, 32'd0);
    check_eq("reset out_flags", 32'(out_flags), 32'd0);

    // Latency = 3 + ceil(lz/4); zero and invalid take 2.
    convert("hw 1",        FUNCT_H_W,  32'd1,        32'hFFFF3C00, 5'b00000, 11);
    convert("hw -2",       FUNCT_H_W,  32'hFFFFFFFE, 32'hFFFFC000, 5'b00000, 11);
    convert("hw -1",       FUNCT_H_W,  32'hFFFFFFFF, 32'hFFFFBC00, 5'b00000, 11);
    convert("hwu max",     FUNCT_H_WU, 32'hFFFFFFFF, 32'hFFFF7C00, 5'b00101, 3);
    convert("hw 65504",    FUNCT_H_W,  32'd65504,    32'hFFFF7BFF, 5'b00000, 7);
    convert("hw 65520",    FUNCT_H_W,  32'd65520,    32'hFFFF7C00, 5'b00101, 7);
    convert("hw 2049",     FUNCT_H_W,  32'd2049,     32'hFFFF6800, 5'b00001, 8);
    // 2051 sits midway between 2050 and 2052; ties go to the even mantissa (2052).
    convert("hw 2051",     FUNCT_H_W,  32'd2051,     32'hFFFF6802, 5'b00001, 8);
    convert("hw 0",        FUNCT_H_W,  32'd0,        32'hFFFF0000, 5'b00000, 2);
    convert("hw min",      FUNCT_H_W,  32'h80000000, 32'hFFFFFC00, 5'b00101, 3);
    convert("w_h invalid", FUNCT_W_H,  32'd7,        32'hFFFF7E00, 5'b10000, 2);

    // Result must hold while the consumer stalls.
    in_valid = 1'b1;
    in_cvt   = FUNCT_H_W;
    in_data  = 32'd2049;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall out_valid", 32'(out_valid), 32'd1);
      check_eq("stall data", out_data, 32'hFFFF6800);
      check_eq("stall flags", 32'(out_flags), 32'd1);
      check_eq("stall in_ready", 32'(in_ready), 32'd0);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check_eq("post-stall in_ready", 32'(in_ready), 32'd1);
    check_eq("post-stall out_valid", 32'(out_valid), 32'd0);
    convert("post-stall 3", FUNCT_H_W, 32'd3, 32'hFFFF4200, 5'b00000, 11);

    abort_in_norm("flush", 1'b0);
    abort_in_norm("rst", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
